// File: rtl/jtdd_vtimer.sv
// Video timing generator: pixel/line counters with registered blanking, sync,
// bus-phase strobes and a raster-line interrupt, all aligned to the counters.
module jtdd_vtimer #(
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int HTOTAL   = 384,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 320,
  parameter int HS_END   = 352,
  parameter int VSTART   = 0,
  parameter int VEND     = 271,
  parameter int VB_START = 240,
  parameter int VB_END   = 8,
  parameter int VS_START = 248,
  parameter int VS_END   = 252,
  parameter int MW       = 6,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic          irq_en,
  input  logic [VW-1:0] irq_line,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBL,
  output logic          VBL,
  output logic          HS,
  output logic          VS,
  output logic          hinit,
  output logic          vinit,
  output logic          virq,
  output logic [FW-1:0] frame,
  output logic [MW-1:0] M
);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_FIRST = VW'(VSTART);
  localparam logic [VW-1:0] V_LAST  = VW'(VEND);

  // Start==end means an empty window; start>end wraps through zero.
  function automatic logic f_window(input int cnt, input int wstart, input int wend);
    if (wstart < wend)
      return (cnt >= wstart) && (cnt < wend);
    else if (wstart == wend)
      return 1'b0;
    else
      return (cnt >= wstart) || (cnt < wend);
  endfunction

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [FW-1:0] r_frame;
  logic          r_hbl, r_vbl, r_hs, r_vs, r_virq;
  logic [MW-1:0] r_m;

  logic          w_hwrap, w_vwrap;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic [MW-1:0] w_m_next;

  always_comb begin
    w_hwrap  = (r_h == H_LAST);
    w_vwrap  = w_hwrap && (r_v == V_LAST);
    w_h_next = w_hwrap ? '0 : r_h + HW'(1);
    if (!w_hwrap)
      w_v_next = r_v;
    else if (r_v == V_LAST)
      w_v_next = V_FIRST;
    else
      w_v_next = r_v + VW'(1);
  end

  // Strobe k fires on odd H whose bits [3:1] equal k.
  always_comb begin
    w_m_next = '0;
    for (int k = 0; k < MW; k++)
      w_m_next[k] = w_h_next[0] && (w_h_next[3:1] == 3'(k));
  end

  // Decodes are loaded from the next counter values so they never lag H/V.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= '0;
      r_v     <= V_FIRST;
      r_frame <= '0;
      r_hbl   <= 1'b0;
      r_vbl   <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_virq  <= 1'b0;
      r_m     <= '0;
    end else if (pxl_cen) begin
      r_h    <= w_h_next;
      r_v    <= w_v_next;
      r_hbl  <= f_window(int'(w_h_next), HB_START, HB_END);
      r_hs   <= f_window(int'(w_h_next), HS_START, HS_END);
      r_vbl  <= f_window(int'(w_v_next), VB_START, VB_END);
      r_vs   <= f_window(int'(w_v_next), VS_START, VS_END);
      r_virq <= irq_en && (w_h_next == '0) && (w_v_next == irq_line);
      r_m    <= w_m_next;
      if (w_vwrap)
        r_frame <= r_frame + FW'(1);
    end
  end

  assign H     = r_h;
  assign V     = r_v;
  assign HPOS  = r_h ^ {HW{flip}};
  assign VPOS  = r_v ^ {VW{flip}};
  assign HBL   = r_hbl;
  assign VBL   = r_vbl;
  assign HS    = r_hs;
  assign VS    = r_vs;
  assign hinit = (r_h == '0);
  assign vinit = (r_h == '0) && (r_v == V_FIRST);
  assign virq  = r_virq;
  assign frame = r_frame;
  assign M     = r_m;

endmodule

// File: doc/jtdd_vtimer.md
# jtdd_vtimer

Parametrised video timing generator for the JTDD core and follow-on ports. It produces the pixel/line counters, blanking and sync strobes, the CPU/video bus-phase strobes and a programmable raster-line interrupt. Geometry is fixed at elaboration through parameters. The block sits between the pixel clock enable and every video consumer: tilemaps, object engine, palette and scan doubler.

## Interface
Parameters:
- HW, 9: horizontal counter width.
- VW, 9: vertical counter width.
- HTOTAL, 384: pixels per line; H counts 0..HTOTAL-1.
- HB_START, 256: first H value with HBL high.
- HB_END, 0: first H value with HBL low.
- HS_START, 320: first H value with HS high.
- HS_END, 352: first H value with HS low.
- VSTART, 0: first line value.
- VEND, 271: last line value; V counts VSTART..VEND.
- VB_START, 240: first V value with VBL high.
- VB_END, 8: first V value with VBL low.
- VS_START, 248: first V value with VS high.
- VS_END, 252: first V value with VS low.
- MW, 6: number of bus-phase strobes (1..8).
- FW, 8: frame counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; all state advances only when high
- flip  in  1  screen flip
- irq_en  in  1  line interrupt enable
- irq_line  in  VW  line that raises virq
- H  out  HW  raw horizontal count
- V  out  VW  raw vertical count
- HPOS  out  HW  H XOR {HW{flip}}
- VPOS  out  VW  V XOR {VW{flip}}; all bits inverted, not only bit 0
- HBL, VBL, HS, VS  out  1  blanking and sync, active high
- hinit  out  1  high while H==0
- vinit  out  1  high while H==0 and V==VSTART
- virq  out  1  line interrupt strobe
- frame  out  FW  frame counter
- M  out  MW  one-hot bus-phase strobes

## Operation
- On each pxl_cen, H advances by 1. From HTOTAL-1 it wraps to 0 and V advances.
- V wraps from VEND to VSTART. A V value outside VSTART..VEND cannot occur after reset.
- Windowed decodes, written for a generic signal X with parameters X_START and X_END:
  - If X_START < X_END, X is high for X_START <= count < X_END.
  - Otherwise the window wraps: X is high for count >= X_START or count < X_END.
  - If X_START == X_END, X is never high.
- These decodes apply to HBL, HS (on H) and VBL, VS (on V).
- All decoded outputs are registered and loaded from the next counter values in the same pxl_cen cycle, so they always match H/V exactly.
- M[k] is high when next-H[0] == 1 and next-H[3:1] == k, for k < MW. At most one bit is high, and M is all zero on even H.
- virq is high while H==0 and V==irq_line and irq_en==1. It lasts exactly one pxl_cen period per frame. If irq_line is outside VSTART..VEND, virq never rises.
- frame increments by 1, modulo 2^FW, on the cen that wraps V to VSTART.
- HPOS and VPOS are combinational XORs of the registered counts, so flip takes effect in the same clk cycle.
- Changing irq_line or irq_en mid-frame is allowed. It takes effect at the next H wrap.

## Timing
- Reset (asynchronous):
  - H=0, V=VSTART, frame=0.
  - HBL, VBL, HS, VS, virq and M = 0.
  - hinit=1 and vinit=1, because they are decoded from the counters.
- The first pxl_cen after reset release moves H to 1, and all decodes reflect H=1, V=VSTART.
- Decoded outputs are consistent with the counters only from that first pxl_cen onward.
- Latency: H, V and every decoded output change on the same clk edge on which pxl_cen is sampled high. They hold between enables.
- A line is HTOTAL cens long, and a frame is HTOTAL*(VEND-VSTART+1) cens long.
- Simultaneous H and V wrap at the end of the frame:
  - V goes to VSTART, frame increments, and vinit, hinit and (if irq_line==VSTART) virq are all high in the same cycle.
- Reset asserted mid-frame clears the state immediately, regardless of pxl_cen.

## Test plan
- Defaults, reset then 384 cens:
  - H returns to 0 and V goes from 0 to 1.
  - HBL rises at H=256 and falls at H=0.
  - HS is high for H=320..351 (32 cens).
- Full frame with defaults:
  - 104448 cens per frame, and frame increments once.
  - VBL is high for V=240..271 and V=0..7.
  - VS is high for V=248..251.
- Bus phase sequence:
  - H=1 gives M=000001, H=3 gives 000010, ... H=11 gives 100000.
  - H=13 and H=15 give M=0, and every even H gives M=0.
- Line interrupt:
  - irq_en=1, irq_line=100: exactly one virq pulse per frame, at V=100, H=0, lasting one cen period.
  - irq_line=300: no pulse.
  - irq_en dropped mid-frame before line 100: no pulse.
- Flip:
  - flip=1 at H=5, V=10 gives HPOS=9'h1FA and VPOS=9'h1F5 in the same clk cycle.
  - H and V are unchanged.
- Reset mid-line at H=200, V=50:
  - Outputs return to the reset values listed above.
  - Counting resumes from H=1 on the first cen after release.
  - Geometry is re-checked with HTOTAL=256, VSTART=8, VEND=263.
